// File: rtl/reg_bank_rd.sv
// 32-entry GPR bank for the multicycle datapath: one write port, two registered
// read ports with same-cycle write-to-read bypass and a capture-valid strobe.
module reg_bank_rd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_INDEX = 29,
    parameter int SP_INIT  = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic              wr_live_s;
    logic [DATA_W-1:0] rd1_next_s;
    logic [DATA_W-1:0] rd2_next_s;

    // Index 0 is never written, so its storage stays at the reset zero.
    assign wr_live_s = reg_write && (write_reg != {ADDR_W{1'b0}});

    // Register storage update; SP gets its boot value on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == SP_INDEX) begin
                    regs_r[i] <= DATA_W'(SP_INIT);
                end else begin
                    regs_r[i] <= {DATA_W{1'b0}};
                end
            end
        end else begin
            if (wr_live_s) begin
                regs_r[write_reg] <= write_data;
            end else begin
                regs_r[write_reg] <= regs_r[write_reg];
            end
        end
    end

    // Operand selection with write-to-read forwarding for each port.
    always_comb begin
        rd1_next_s = regs_r[read_reg1];
        rd2_next_s = regs_r[read_reg2];
        if (wr_live_s && (write_reg == read_reg1)) begin
            rd1_next_s = write_data;
        end else begin
            rd1_next_s = regs_r[read_reg1];
        end
        if (wr_live_s && (write_reg == read_reg2)) begin
            rd2_next_s = write_data;
        end else begin
            rd2_next_s = regs_r[read_reg2];
        end
    end

    // Operand capture registers; outputs hold when no capture is requested.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data1 <= {DATA_W{1'b0}};
            read_data2 <= {DATA_W{1'b0}};
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= read_en;
            if (read_en) begin
                read_data1 <= rd1_next_s;
                read_data2 <= rd2_next_s;
            end else begin
                read_data1 <= read_data1;
                read_data2 <= read_data2;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_rd.sv
// Self-checking bench for reg_bank_rd: directed scenarios followed by random
// traffic compared against an array-based reference model of the register file.
module tb_reg_bank_rd;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          reg_write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic          read_en;
    logic [AW-1:0] read_reg1;
    logic [AW-1:0] read_reg2;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic          rd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mdl [32];
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
    logic          expv;

    reg_bank_rd dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_en    (read_en),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, req);
        end
    endtask

    task automatic model_reset();
        foreach (mdl[i]) mdl[i] = 32'd0;
        mdl[29] = 32'd227;
        exp1 = 32'd0;
        exp2 = 32'd0;
        expv = 1'b0;
    endtask

    task automatic set(input logic rw, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        reg_write  = rw;
        write_reg  = wr;
        write_data = wd;
        read_en    = re;
        read_reg1  = r1;
        read_reg2  = r2;
    endtask

    // One clock edge: predict from the model, advance, compare all outputs.
    task automatic tick(input string tag);
        if (read_en) begin
            exp1 = (reg_write && write_reg != 5'd0 && write_reg == read_reg1) ? write_data : mdl[read_reg1];
            exp2 = (reg_write && write_reg != 5'd0 && write_reg == read_reg2) ? write_data : mdl[read_reg2];
        end
        expv = read_en;
        if (reg_write && write_reg != 5'd0) mdl[write_reg] = write_data;
        @(posedge clk);
        #1;
        chk({tag, "_rd1"}, read_data1, exp1);
        chk({tag, "_rd2"}, read_data2, exp2);
        chk({tag, "_vld"}, {31'd0, rd_valid}, {31'd0, expv});
    endtask

    // Asynchronous reset pulse raised mid-cycle, held across one edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_async_rd1"}, read_data1, 32'd0);
        chk({tag, "_async_rd2"}, read_data2, 32'd0);
        chk({tag, "_async_vld"}, {31'd0, rd_valid}, 32'd0);
        set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("por_rd1", read_data1, 32'd0);
        chk("por_vld", {31'd0, rd_valid}, 32'd0);

        // Test 1: dirty r5, then async reset restores defaults
        set(1'b1, 5'd5, 32'h0000_0055, 1'b0, 5'd0, 5'd0);
        tick("t1_pre");
        do_reset("t1");
        set(1'b0, 5'd0, 32'd0, 1'b1, 5'd29, 5'd5);
        tick("t1_rd");
        chk("t1_r29", read_data1, 32'd227);
        chk("t1_r5", read_data2, 32'd0);
        chk("t1_vld", {31'd0, rd_valid}, 32'd1);

        // Test 2: write then read, valid is a single-cycle pulse
        set(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
        tick("t2_wr");
        set(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd0);
        tick("t2_rd");
        chk("t2_r8", read_data1, 32'hDEAD_BEEF);
        chk("t2_r0", read_data2, 32'd0);
        chk("t2_vld", {31'd0, rd_valid}, 32'd1);
        set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        tick("t2_idle");
        chk("t2_vld_drop", {31'd0, rd_valid}, 32'd0);

        // Test 3: same-cycle bypass on both ports
        set(1'b1, 5'd9, 32'h1234_5678, 1'b1, 5'd9, 5'd9);
        tick("t3");
        chk("t3_byp1", read_data1, 32'h1234_5678);
        chk("t3_byp2", read_data2, 32'h1234_5678);

        // Test 4: r0 is immune to writes and bypass
        set(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0);
        tick("t4_wr");
        chk("t4_nobyp", read_data1, 32'd0);
        set(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        tick("t4_rd");
        chk("t4_r0", read_data1, 32'd0);

        // Test 5: outputs hold while read_en is low
        set(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd8);
        tick("t5_cap");
        chk("t5_cap_r8", read_data1, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            set(1'b1, 5'd8, 32'h0000_0001, 1'b0, 5'd0, 5'd0);
            tick("t5_hold");
            chk("t5_hold_r8", read_data1, 32'hDEAD_BEEF);
        end
        set(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd0);
        tick("t5_rd");
        chk("t5_new_r8", read_data1, 32'h0000_0001);

        // Test 6: write in flight at reset is discarded
        set(1'b1, 5'd10, 32'h0000_00AA, 1'b0, 5'd0, 5'd0);
        do_reset("t6");
        set(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd29);
        tick("t6_rd");
        chk("t6_r10", read_data1, 32'd0);
        chk("t6_r29", read_data2, 32'd227);

        // Random traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] wr;
            wr = 5'($urandom_range(0, 31));
            set(1'($urandom_range(0, 1)), wr, $urandom, 1'($urandom_range(0, 2) != 0),
                ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
                ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
            tick("rnd");
            if (i == 200) do_reset("rnd_rst");
        end

        // Final sweep of every register through both ports
        for (int i = 0; i < 32; i++) begin
            set(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(31 - i));
            tick("sweep");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
